// File: rtl/echo_median5_filter_if.sv
// Echo median filter bus: tick samples in, median strobe and status out.
// The master side is the upstream measurement stage driving samples.
interface echo_median5_filter_if #(
   parameter int WIDTH = 21
);
   logic             in_valid;
   logic [WIDTH-1:0] in_ticks;
   logic             in_timeout;
   logic             out_valid;
   logic [WIDTH-1:0] out_ticks;
   logic             busy;
   logic [2:0]       fill;
   logic [7:0]       reject_cnt;

   modport master (
      output in_valid,
      output in_ticks,
      output in_timeout,
      input  out_valid,
      input  out_ticks,
      input  busy,
      input  fill,
      input  reject_cnt
   );

   modport slave (
      input  in_valid,
      input  in_ticks,
      input  in_timeout,
      output out_valid,
      output out_ticks,
      output busy,
      output fill,
      output reject_cnt
   );
endinterface

// File: rtl/echo_median5_filter.sv
// 5-tap sliding median over in-range echo tick counts (odd-even sort).
// Define MEDIAN_TIMEOUT_FLUSH_EN to let in_timeout flush the window.
module echo_median5_filter #(
   parameter int WIDTH     = 21,
   parameter int MIN_TICKS = 7500,
   parameter int MAX_TICKS = 1250000
) (
   input logic                  clk,
   input logic                  rst_n,
   echo_median5_filter_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SORT = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]       state;
   logic [2:0]       pass;
   logic [WIDTH-1:0] win     [5];
   logic [WIDTH-1:0] srt     [5];
   logic [WIDTH-1:0] srt_nxt [5];
   logic [WIDTH-1:0] pend;
   logic             pend_vld;

   logic             out_valid;
   logic [WIDTH-1:0] out_ticks;
   logic             busy;
   logic [2:0]       fill;
   logic [2:0]       fill_nxt;
   logic [7:0]       reject_cnt;

   logic             in_range;
   logic             acc;
   logic             rej;
   logic             take;
   logic             flush;
   logic [WIDTH-1:0] smp;

   assign in_range = (bus.in_ticks >= WIDTH'(MIN_TICKS)) &&
                     (bus.in_ticks <= WIDTH'(MAX_TICKS));
   assign acc      = bus.in_valid & in_range;
   assign rej      = bus.in_valid & ~in_range;

`ifdef MEDIAN_TIMEOUT_FLUSH_EN
   assign flush = bus.in_timeout & ~bus.in_valid;
`else
   logic timeout_unused;
   assign timeout_unused = bus.in_timeout;
   assign flush          = 1'b0;
`endif

   // A fresh arrival in IDLE wins over a stale pending sample.
   assign take     = (state == S_IDLE) && (acc || pend_vld);
   assign smp      = acc ? bus.in_ticks : pend;
   assign fill_nxt = (fill == 3'd5) ? 3'd5 : fill + 3'd1;

   always_comb begin
      srt_nxt = srt;
      if (!pass[0]) begin
         if (srt[0] > srt[1]) begin
            srt_nxt[0] = srt[1];
            srt_nxt[1] = srt[0];
         end
         if (srt[2] > srt[3]) begin
            srt_nxt[2] = srt[3];
            srt_nxt[3] = srt[2];
         end
      end else begin
         if (srt[1] > srt[2]) begin
            srt_nxt[1] = srt[2];
            srt_nxt[2] = srt[1];
         end
         if (srt[3] > srt[4]) begin
            srt_nxt[3] = srt[4];
            srt_nxt[4] = srt[3];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pass       <= 3'd0;
         pend       <= '0;
         pend_vld   <= 1'b0;
         out_valid  <= 1'b0;
         out_ticks  <= '0;
         busy       <= 1'b0;
         fill       <= 3'd0;
         reject_cnt <= 8'd0;
         for (int i = 0; i < 5; i++) begin
            win[i] <= '0;
            srt[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;

         if (rej && (reject_cnt != 8'hff)) begin
            reject_cnt <= reject_cnt + 8'd1;
         end

         if (flush) begin
            state    <= S_IDLE;
            pass     <= 3'd0;
            busy     <= 1'b0;
            fill     <= 3'd0;
            pend     <= '0;
            pend_vld <= 1'b0;
            for (int i = 0; i < 5; i++) begin
               win[i] <= '0;
            end
         end else begin
            if (acc && (state != S_IDLE)) begin
               pend     <= bus.in_ticks;
               pend_vld <= 1'b1;
            end

            unique case (state)
               S_IDLE: begin
                  if (take) begin
                     pend_vld <= 1'b0;
                     win[0]   <= smp;
                     for (int i = 1; i < 5; i++) begin
                        win[i] <= win[i-1];
                     end
                     fill <= fill_nxt;
                     if (fill_nxt == 3'd5) begin
                        srt[0] <= smp;
                        for (int i = 1; i < 5; i++) begin
                           srt[i] <= win[i-1];
                        end
                        pass  <= 3'd0;
                        busy  <= 1'b1;
                        state <= S_SORT;
                     end
                  end
               end
               S_SORT: begin
                  srt <= srt_nxt;
                  if (pass == 3'd4) begin
                     state <= S_OUT;
                  end else begin
                     pass <= pass + 3'd1;
                  end
               end
               S_OUT: begin
                  out_ticks <= srt[2];
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.out_valid  = out_valid;
   assign bus.out_ticks  = out_ticks;
   assign bus.busy       = busy;
   assign bus.fill       = fill;
   assign bus.reject_cnt = reject_cnt;

endmodule

// File: tb/tb_echo_median5_filter.sv
// Scoreboard bench for echo_median5_filter: directed samples, queued medians.
// Build with MEDIAN_TIMEOUT_FLUSH_EN to exercise the flush path.
module tb_echo_median5_filter;

   localparam int W = 21;

   typedef struct {
      logic [W-1:0] t;
      int           c;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   n_strobe;
   int   last_drv;
   int   s0;
   exp_t q[$];

   echo_median5_filter_if #(.WIDTH(W)) bus ();

   echo_median5_filter #(
      .WIDTH(W),
      .MIN_TICKS(7500),
      .MAX_TICKS(1250000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic send(input int t);
      @(negedge clk);
      last_drv     = cyc;
      bus.in_valid = 1'b1;
      bus.in_ticks = W'(t);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic push(input int t, input int c);
      exp_t e;
      e.t = W'(t);
      e.c = c;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic feed(input int t, input int med);
      send(t);
      if (med >= 0) push(med, 0);
      idle(20);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         exp_t e;
         n_strobe++;
         if (q.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            e = q.pop_front();
            check("median", int'(bus.out_ticks), int'(e.t));
            if (e.c != 0) check("latency_cycle", cyc, e.c);
         end
      end
   end

   initial begin
      cyc            = 0;
      n_chk          = 0;
      n_pass         = 0;
      n_strobe       = 0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_ticks   = '0;
      bus.in_timeout = 1'b0;
      idle(3);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_out_ticks", int'(bus.out_ticks), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_fill", int'(bus.fill), 0);
      check("rst_reject", int'(bus.reject_cnt), 0);
      rst_n = 1'b1;
      idle(2);

      for (int i = 1; i <= 4; i++) begin
         send(i * 10000);
         check("fill_ramp", int'(bus.fill), i);
         idle(100);
      end
      send(50000);
      push(30000, last_drv + 7);
      check("busy_after_5th", int'(bus.busy), 1);
      idle(20);
      check("fill_full", int'(bus.fill), 5);

      feed(900000, 40000);
      feed(1000, -1);
      check("reject_1", int'(bus.reject_cnt), 1);
      check("fill_after_reject", int'(bus.fill), 5);

      feed(7500, 40000);
      feed(1250000, 50000);
      feed(7499, -1);
      feed(1250001, -1);
      check("reject_bounds", int'(bus.reject_cnt), 3);
      for (int i = 0; i < 300; i++) send(1000);
      idle(5);
      check("reject_sat", int'(bus.reject_cnt), 255);

      s0 = n_strobe;
      send(60000);
      send(15000);
      send(16000);
      push(60000, 0);
      push(60000, 0);
      idle(30);
      check("busy_strobes", n_strobe - s0, 2);

      send(70000);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", int'(bus.out_valid), 0);
      check("mid_rst_out_ticks", int'(bus.out_ticks), 0);
      check("mid_rst_busy", int'(bus.busy), 0);
      check("mid_rst_fill", int'(bus.fill), 0);
      check("mid_rst_reject", int'(bus.reject_cnt), 0);
      idle(3);
      rst_n = 1'b1;
      idle(20);

      for (int i = 1; i <= 4; i++) feed(i * 10000, -1);
      feed(50000, 30000);
      @(negedge clk);
      bus.in_timeout = 1'b1;
      @(negedge clk);
      bus.in_timeout = 1'b0;
      idle(2);
`ifdef MEDIAN_TIMEOUT_FLUSH_EN
      check("flush_fill", int'(bus.fill), 0);
      check("flush_out_ticks", int'(bus.out_ticks), 30000);
      for (int i = 11; i <= 14; i++) feed(i * 1000, -1);
      check("flush_refill", int'(bus.fill), 4);
      feed(15000, 13000);
`else
      check("noflush_fill", int'(bus.fill), 5);
      check("noflush_out_ticks", int'(bus.out_ticks), 30000);
      feed(11000, 30000);
`endif

      idle(20);
      check("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
